alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
- 32-bit registered arithmetic/logic unit for the processor datapath.
- Takes two operands and a 4-bit operation code, and produces a 32-bit result plus ARM-style condition flags {N,Z,C,V}.
- Result and flags are registered, so downstream condition logic sees them one cycle after the operands are applied.

Parameters:
- WIDTH, 32, operand/result width. Flag and shift rules assume 32; shift amount is b[4:0].

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-high reset.
- a  input  32  operand A.
- b  input  32  operand B.
- control  input  4  operation select.
- result  output  32  registered operation result.
- ALUFlags  output  4  registered flags: [3]=N, [2]=Z, [1]=C, [0]=V.

Behaviour:
- Only synchronous logic: on each rising clk edge, if reset=1 then result<=0 and ALUFlags<=0, else result and ALUFlags take the combinational value of the selected operation on the current a, b and control.
- Reset has priority over any operation; a reset asserted mid-stream clears both outputs on that edge.
- Latency: exactly 1 cycle, with a new operation accepted every cycle. There is no handshake, no stall and no internal state beyond the output registers.
- Operation encoding (control):
  - 0000 ADD: a+b
  - 0001 SUB: a-b
  - 0010 AND: a&b
  - 0011 ORR: a|b
  - 0100 EOR: a^b
  - 0101 BIC: a&~b
  - 0110 MOV: b
  - 0111 MVN: ~b
  - 1000 LSL: a<<b[4:0]
  - 1001 LSR: logical right shift of a by b[4:0]
  - 1010 ASR: arithmetic right shift of a by b[4:0]
  - 1011 ROR: rotate a right by b[4:0]
  - 1100 MUL: low 32 bits of a*b (unsigned and signed give the same low word)
  - 1101 RSB: b-a
  - 1110 SLT: 1 if signed a<b, else 0
  - 1111 SLTU: 1 if unsigned a<b, else 0
- Arithmetic is modulo 2^32; no saturation.
- N = result[31] for every operation.
- Z = (result==0) for every operation.
- C (carry) flag:
  - ADD: carry out of bit 31.
  - SUB: NOT borrow, i.e. 1 when a>=b unsigned.
  - RSB: 1 when b>=a unsigned.
  - LSL: last bit shifted out, a[32-sh]; 0 when sh=0.
  - LSR and ASR: a[sh-1]; 0 when sh=0.
  - ROR: result[31]; 0 when sh=0.
  - All other operations: 0.
- V (overflow) flag:
  - ADD: set when a and b have the same sign and the result sign differs.
  - SUB: set when a and b have different signs and the result sign differs from a.
  - RSB: as SUB with the operands swapped.
  - All other operations: 0.
- Boundary rules:
  - ASR by 0 returns a unchanged.
  - ASR of a negative value by 31 gives 0xFFFFFFFF.
  - ROR by 0 returns a unchanged.
  - Shift amounts use b[4:0] only; b[31:5] are ignored.
- Inputs may change every cycle; each output always reflects the inputs sampled at the previous edge.

Test Plan:
- Reset held for 2 cycles with a=3, b=3, control=0001 -> result=0, ALUFlags=0000; after release, one edge later result=0x00000000, ALUFlags=0110 (Z=1, C=1).
- ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, ALUFlags=1001 (N, V); ADD a=0xFFFFFFFF, b=1 -> result=0, ALUFlags=0110.
- SUB a=2, b=5 -> result=0xFFFFFFFD, ALUFlags=1000; SUB a=0x80000000, b=1 -> result=0x7FFFFFFF, ALUFlags=0011.
- Logic ops with a=0xF0F0F0F0, b=0xFF00FF00:
  - AND -> 0xF000F000, ALUFlags=1000
  - ORR -> 0xFFF0FFF0
  - EOR -> 0x0FF00FF0, ALUFlags=0000
  - BIC -> 0x00F000F0
  - MVN -> 0x00FF00FF
- Shifts with a=0x80000001:
  - LSL b=1 -> 0x00000002, C=1
  - LSR b=1 -> 0x40000000, C=1
  - ASR b=31 -> 0xFFFFFFFF, N=1
  - ROR b=1 -> 0xC0000000, C=1
  - b=0x20 -> shift amount 0, result=a, C=0
- Back-to-back ops on consecutive cycles give results 1 cycle delayed, in order:
  - MUL a=0x10000, b=0x10000 -> 0, Z=1
  - SLT a=0xFFFFFFFF, b=1 -> 1
  - SLTU same operands -> 0, Z=1
  - RSB a=1, b=3 -> 2, C=1

Source files
------------

// File: rtl/alu_unit.sv
// ---------------------------------------------------------------------------
// alu_unit
//   Registered 32-bit arithmetic/logic unit for the processor datapath.
//   Every cycle the operation selected by `control` is evaluated on `a` and
//   `b`, and the 32-bit result together with ARM-style condition flags
//   {N,Z,C,V} is captured on the next rising clock edge. There is no
//   handshake and no internal state other than the output registers.
//
// Ports
//   clk       in   1   system clock, rising-edge active
//   reset     in   1   synchronous active-high reset (clears result/flags)
//   a         in  32   operand A
//   b         in  32   operand B (b[4:0] is the shift amount for shifts)
//   control   in   4   operation select
//   result    out 32   registered operation result
//   ALUFlags  out  4   registered flags: [3]=N [2]=Z [1]=C [0]=V
// ---------------------------------------------------------------------------
module alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       ALUFlags
);

  // Operation encodings
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_ORR  = 4'b0011;
  localparam logic [3:0] OP_EOR  = 4'b0100;
  localparam logic [3:0] OP_BIC  = 4'b0101;
  localparam logic [3:0] OP_MOV  = 4'b0110;
  localparam logic [3:0] OP_MVN  = 4'b0111;
  localparam logic [3:0] OP_LSL  = 4'b1000;
  localparam logic [3:0] OP_LSR  = 4'b1001;
  localparam logic [3:0] OP_ASR  = 4'b1010;
  localparam logic [3:0] OP_ROR  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_RSB  = 4'b1101;
  localparam logic [3:0] OP_SLT  = 4'b1110;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  // Pack the four condition flags; N and Z always derive from the result.
  function automatic logic [3:0] pack_flags(
    input logic [WIDTH-1:0] res,
    input logic             carry,
    input logic             ovf
  );
    pack_flags = {res[WIDTH-1], (res == {WIDTH{1'b0}}), carry, ovf};
  endfunction

  // Signed overflow of x + y (or x - y when y is passed pre-inverted sign):
  // operands agree in sign and the result sign disagrees.
  function automatic logic add_ovf(
    input logic sx,
    input logic sy,
    input logic sr
  );
    add_ovf = (sx == sy) && (sr != sx);
  endfunction

  logic [4:0]       sh_s;        // shift amount, upper bits of b ignored
  logic [WIDTH:0]   add_s;       // {carry, sum}
  logic [WIDTH:0]   sub_s;       // {borrow, a-b}
  logic [WIDTH:0]   rsb_s;       // {borrow, b-a}
  logic [WIDTH:0]   lsl_s;       // {last bit out, a<<sh}
  logic [WIDTH:0]   lsr_s;       // {a>>sh, last bit out}
  logic [WIDTH:0]   asr_s;       // {a>>>sh, last bit out}
  logic [WIDTH-1:0] ror_s;
  logic [WIDTH-1:0] mul_s;
  logic             slt_s;
  logic             sltu_s;
  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic             ovf_s;

  assign sh_s  = b[4:0];
  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} - {1'b0, b};
  assign rsb_s = {1'b0, b} - {1'b0, a};

  // Widening by one bit on the side the data leaves captures the last bit
  // shifted out; with a zero shift that extra bit is the zero pad.
  assign lsl_s = {1'b0, a} << sh_s;
  assign lsr_s = {a, 1'b0} >> sh_s;
  assign asr_s = $signed({a, 1'b0}) >>> sh_s;

  // A left shift by 32 yields zero, so sh=0 naturally returns a unchanged.
  assign ror_s = (a >> sh_s) | (a << (6'd32 - {1'b0, sh_s}));

  assign mul_s  = a * b;
  assign slt_s  = $signed(a) < $signed(b);
  assign sltu_s = a < b;

  // Operation select: result, carry and overflow for the current inputs.
  always_comb begin
    res_s   = {WIDTH{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (control)
      OP_ADD: begin
        res_s   = add_s[WIDTH-1:0];
        carry_s = add_s[WIDTH];
        ovf_s   = add_ovf(a[WIDTH-1], b[WIDTH-1], add_s[WIDTH-1]);
      end
      OP_SUB: begin
        res_s   = sub_s[WIDTH-1:0];
        carry_s = ~sub_s[WIDTH];
        ovf_s   = add_ovf(a[WIDTH-1], ~b[WIDTH-1], sub_s[WIDTH-1]);
      end
      OP_AND: res_s = a & b;
      OP_ORR: res_s = a | b;
      OP_EOR: res_s = a ^ b;
      OP_BIC: res_s = a & ~b;
      OP_MOV: res_s = b;
      OP_MVN: res_s = ~b;
      OP_LSL: begin
        res_s   = lsl_s[WIDTH-1:0];
        carry_s = lsl_s[WIDTH];
      end
      OP_LSR: begin
        res_s   = lsr_s[WIDTH:1];
        carry_s = lsr_s[0];
      end
      OP_ASR: begin
        res_s   = asr_s[WIDTH:1];
        carry_s = asr_s[0];
      end
      OP_ROR: begin
        res_s = ror_s;
        if (sh_s != 5'd0) begin
          carry_s = ror_s[WIDTH-1];
        end else begin
          carry_s = 1'b0;
        end
      end
      OP_MUL: res_s = mul_s;
      OP_RSB: begin
        res_s   = rsb_s[WIDTH-1:0];
        carry_s = ~rsb_s[WIDTH];
        ovf_s   = add_ovf(b[WIDTH-1], ~a[WIDTH-1], rsb_s[WIDTH-1]);
      end
      OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, slt_s};
      OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, sltu_s};
      default: begin
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
      end
    endcase
  end

  // Output registers: reset clears both, otherwise capture this cycle's op.
  always_ff @(posedge clk) begin
    if (reset) begin
      result   <= {WIDTH{1'b0}};
      ALUFlags <= 4'b0000;
    end else begin
      result   <= res_s;
      ALUFlags <= pack_flags(res_s, carry_s, ovf_s);
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
module tb_alu_unit;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  control;
  logic [31:0] result;
  logic [3:0]  ALUFlags;

  alu_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .control  (control),
    .result   (result),
    .ALUFlags (ALUFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic drv_valid = 1'b0;

  // Reference model: evaluates the operation with plain integer arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] x,
                                input logic [31:0] y, output logic [31:0] r,
                                output logic [3:0] f);
    longint s;
    longint sv;
    int     sh;
    logic   c;
    logic   v;
    sh = int'(y[4:0]);
    c  = 1'b0;
    v  = 1'b0;
    r  = 32'd0;
    case (op)
      4'd0: begin
        s  = longint'(x) + longint'(y);
        r  = s[31:0];
        c  = s[32];
        sv = longint'($signed(x)) + longint'($signed(y));
        v  = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      4'd1: begin
        r  = x - y;
        c  = (x >= y);
        sv = longint'($signed(x)) - longint'($signed(y));
        v  = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = x & ~y;
      4'd6: r = y;
      4'd7: r = ~y;
      4'd8: begin
        r = x << sh;
        c = (sh == 0) ? 1'b0 : x[32-sh];
      end
      4'd9: begin
        r = x >> sh;
        c = (sh == 0) ? 1'b0 : x[sh-1];
      end
      4'd10: begin
        sv = longint'($signed(x));
        for (int i = 0; i < sh; i++) sv = sv / 2 - ((sv % 2 != 0 && sv < 0) ? 1 : 0);
        r = sv[31:0];
        c = (sh == 0) ? 1'b0 : x[sh-1];
      end
      4'd11: begin
        r = x;
        for (int i = 0; i < sh; i++) r = {r[0], r[31:1]};
        c = (sh == 0) ? 1'b0 : r[31];
      end
      4'd12: begin
        s = longint'(x) * longint'(y);
        r = s[31:0];
      end
      4'd13: begin
        r  = y - x;
        c  = (y >= x);
        sv = longint'($signed(y)) - longint'($signed(x));
        v  = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      4'd14: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd15: r = (x < y) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    f = {r[31], (r == 32'd0), c, v};
  endfunction

  // Drive one cycle of stimulus and record what the DUT must show next edge.
  task automatic issue(input logic rst, input logic [3:0] op,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input logic [3:0] ef,
                       input string nm);
    exp_t e;
    @(negedge clk);
    reset     = rst;
    control   = op;
    a         = x;
    b         = y;
    e.res     = er;
    e.flg     = ef;
    e.name    = nm;
    exp_q.push_back(e);
    drv_valid = 1'b1;
  endtask

  task automatic issue_model(input logic rst, input logic [3:0] op,
                             input logic [31:0] x, input logic [31:0] y,
                             input string nm);
    logic [31:0] r;
    logic [3:0]  f;
    model(op, x, y, r, f);
    if (rst) begin
      r = 32'd0;
      f = 4'd0;
    end
    issue(rst, op, x, y, r, f, nm);
  endtask

  // Monitor: after each edge that captured issued stimulus, pop and compare.
  initial begin
    logic v;
    exp_t e;
    forever begin
      @(posedge clk);
      v = drv_valid;
      #1;
      if (v) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_underflow result=%h flags=%b", result, ALUFlags);
        end else begin
          e = exp_q.pop_front();
          total++;
          if (result !== e.res || ALUFlags !== e.flg) begin
            bad++;
            $display("FAIL %s got result=%h flags=%b want result=%h flags=%b",
                     e.name, result, ALUFlags, e.res, e.flg);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rop;
    logic        rrst;
    int          wait_cnt;
    reset   = 1'b1;
    a       = 32'd3;
    b       = 32'd3;
    control = 4'b0001;

    issue(1'b1, 4'b0001, 32'd3, 32'd3, 32'd0, 4'b0000, "reset_c1");
    issue(1'b1, 4'b0001, 32'd3, 32'd3, 32'd0, 4'b0000, "reset_c2");
    issue(1'b0, 4'b0001, 32'd3, 32'd3, 32'd0, 4'b0110, "sub_eq_after_reset");

    issue(1'b0, 4'b0000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b1001, "add_ovf");
    issue(1'b0, 4'b0000, 32'hFFFFFFFF, 32'd1, 32'h00000000, 4'b0110, "add_carry");
    issue(1'b0, 4'b0001, 32'd2, 32'd5, 32'hFFFFFFFD, 4'b1000, "sub_neg");
    issue(1'b0, 4'b0001, 32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b0011, "sub_ovf");

    issue(1'b0, 4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, "and");
    issue(1'b0, 4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 4'b1000, "orr");
    issue(1'b0, 4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0000, "eor");
    issue(1'b0, 4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00F000F0, 4'b0000, "bic");
    issue(1'b0, 4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00FF00FF, 4'b0000, "mvn");

    issue(1'b0, 4'b1000, 32'h80000001, 32'd1,  32'h00000002, 4'b0010, "lsl1");
    issue(1'b0, 4'b1001, 32'h80000001, 32'd1,  32'h40000000, 4'b0010, "lsr1");
    issue(1'b0, 4'b1010, 32'h80000001, 32'd31, 32'hFFFFFFFF, 4'b1000, "asr31");
    issue(1'b0, 4'b1011, 32'h80000001, 32'd1,  32'hC0000000, 4'b1010, "ror1");
    issue(1'b0, 4'b1000, 32'h80000001, 32'h20, 32'h80000001, 4'b1000, "lsl_sh32");
    issue(1'b0, 4'b1010, 32'h80000001, 32'h20, 32'h80000001, 4'b1000, "asr_sh0");
    issue(1'b0, 4'b1011, 32'h80000001, 32'h20, 32'h80000001, 4'b1000, "ror_sh0");

    issue(1'b0, 4'b1100, 32'h10000, 32'h10000, 32'd0, 4'b0100, "mul_wrap");
    issue(1'b0, 4'b1110, 32'hFFFFFFFF, 32'd1, 32'd1, 4'b0000, "slt");
    issue(1'b0, 4'b1111, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0100, "sltu");
    issue(1'b0, 4'b1101, 32'd1, 32'd3, 32'd2, 4'b0010, "rsb");

    // Reset mid-stream clears a pending operation on that same edge.
    issue(1'b1, 4'b0000, 32'h7FFFFFFF, 32'd1, 32'd0, 4'b0000, "reset_midstream");
    issue(1'b0, 4'b0110, 32'h0, 32'h80000000, 32'h80000000, 4'b1000, "mov_after_reset");

    // Randomized traffic, with occasional resets and corner operand values.
    for (int n = 0; n < 400; n++) begin
      rop  = 4'($urandom_range(0, 15));
      ra   = $urandom;
      rb   = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: rb = ra;
        2: rb = {27'($urandom), 5'($urandom_range(0, 31))} & 32'h0000003F;
        default: ra = ra;
      endcase
      rrst = ($urandom_range(0, 29) == 0);
      issue_model(rrst, rop, ra, rb, "random");
    end

    @(negedge clk);
    drv_valid = 1'b0;
    reset     = 1'b0;
    wait_cnt  = 0;
    while (exp_q.size() != 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
